decode_read: RTL and testbench
==============================

DECODE_READ -- requirements
Module: decode_read

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the fetch-to-decode handshake.
REQ-004 SHALL have ports D_icode, D_ifun, D_rA, D_rB (input, 4 each) and D_valC, D_valP (input, 64 each): the instruction being decoded.
REQ-005 SHALL have ports R0..R14 (input, 64 each): register file contents, one port per register, consumed by this block.
REQ-006 SHALL have ports e_dstE (input, 4) and e_valE (input, 64): the execute-stage forward.
REQ-007 SHALL have ports M_dstM, M_dstE (input, 4) and m_valM, M_valE (input, 64): the memory-stage forwards.
REQ-008 SHALL have ports W_dstM, W_dstE (input, 4) and W_valM, W_valE (input, 64): the writeback-stage forwards.
REQ-009 SHALL have port flush, input, 1 bit: mispredict/ret squash.
REQ-010 SHALL have E_valid, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM, E_valC, E_valA, E_valB (output, registered): the execute pipeline register.
REQ-011 SHALL have port load_use, output, 1 bit, combinational: the hazard flag.

Function
REQ-012 SHALL use register numbering 0..14 (register 4 = rsp) and 4'hF = RNONE.
REQ-013 srcA SHALL be rA for icode 2, 4, 6 and A; 4 for icode 9 and B; RNONE otherwise.
REQ-014 srcB SHALL be rB for icode 4, 5 and 6; 4 for icode 8, 9, A and B; RNONE otherwise.
REQ-015 dstE SHALL be rB for icode 2, 3 and 6; 4 for icode 8, 9, A and B; RNONE otherwise. cmov nullification happens downstream.
REQ-016 dstM SHALL be rA for icode 5 and B; RNONE otherwise.
REQ-017 Any icode > B, and icode 0 or 1, SHALL use RNONE for all src and dst fields; the instruction still passes to E.
REQ-018 valA SHALL be D_valP for icode 7 and 8.
REQ-019 Otherwise valA SHALL take the first matching forward in this order: e_dstE, M_dstM, M_dstE, W_dstM, W_dstE; else R[srcA]; 0 if srcA = RNONE.
REQ-020 valB SHALL use the same forward priority as valA, without the valP case.
REQ-021 A forward match SHALL require dst == src and src != RNONE.
REQ-022 load_use SHALL be 1 when E_valid=1, E_icode is 5 or B, E_dstM != RNONE, and E_dstM equals srcA or srcB of the current D instruction.
REQ-023 in_ready SHALL equal ~load_use.
REQ-024 An instruction SHALL be accepted only when in_valid and in_ready are both 1.
REQ-025 On an accepted cycle, the E register SHALL load the decoded fields with E_valid=1.
REQ-026 Latency SHALL be one cycle.
REQ-027 On load_use, or when in_valid=0, E SHALL load a bubble; D is held by the upstream stage.
REQ-028 A bubble SHALL be: E_valid=0, E_icode=1, E_ifun=0, all src/dst fields = F, all 64-bit fields = 0.
REQ-029 flush SHALL force a bubble into E, overriding both accept and load_use.
REQ-030 load_use SHALL still be driven during flush.
REQ-031 Back-to-back accepted instructions SHALL be sustained at one per cycle.

Reset
REQ-032 While rst_n=0, E SHALL asynchronously hold the bubble values of REQ-028.
REQ-033 Reset asserted mid-operation SHALL discard the in-flight E contents.
REQ-034 The first posedge after rst_n rises SHALL behave normally.

Structure
REQ-035 Icode constants, RNONE and RRSP SHALL live in the shared package y86_pkg.
REQ-036 Forward selection SHALL be one sub-module, fwd_sel, instantiated once for valA and once for valB.

Verification
REQ-037 Scenario: rst_n=0 mid-stream -> E_valid=0, E_icode=1, E_dstE=F without a clock edge.
REQ-038 Scenario: OPq rA=2 rB=3, R2=5, R3=7, no forwards -> next cycle E_valA=5, E_valB=7, E_dstE=3.
REQ-039 Scenario: rA=2 with e_dstE=2 (e_valE=0x11), M_dstE=2 (M_valE=0x22) and W_dstM=2 -> E_valA=0x11.
REQ-040 Scenario: E holds mrmovq with dstM=6, D is OPq rA=6 -> load_use=1, in_ready=0, E bubble next cycle, then accepted.
REQ-041 Scenario: call with D_valP=0x40, R4=0x100 -> E_valA=0x40, E_valB=0x100, E_dstE=4.
REQ-042 Scenario: flush with a valid instruction and load_use both present -> E bubble.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the execute pipeline register layout.
// Imported by the decode/read stage and its forwarding selector.
package y86_pkg;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RRSP    = 4'h4;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
    } ereg_t;

    localparam ereg_t E_BUBBLE = '{
        valid: 1'b0,
        icode: INOP,
        ifun:  4'h0,
        srca:  RNONE,
        srcb:  RNONE,
        dste:  RNONE,
        dstm:  RNONE,
        valc:  64'h0,
        vala:  64'h0,
        valb:  64'h0
    };

endpackage

// File: rtl/fwd_sel.sv
// Operand forward selector: picks the youngest in-flight producer of src, else the register file value.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fwd_sel
    import y86_pkg::*;
(
    input  logic [3:0]  src,
    input  logic [63:0] rf_val,
    input  logic [3:0]  e_dste,
    input  logic [63:0] e_vale,
    input  logic [3:0]  m_dstm,
    input  logic [63:0] m_valm,
    input  logic [3:0]  m_dste,
    input  logic [63:0] m_vale,
    input  logic [3:0]  w_dstm,
    input  logic [63:0] w_valm,
    input  logic [3:0]  w_dste,
    input  logic [63:0] w_vale,
    output logic [63:0] val
);

    // RNONE never forwards, even when a stage's dst is also RNONE.
    always_comb begin
        val = rf_val;
        if (src != RNONE) begin
            if (src == e_dste)
                val = e_vale;
            else if (src == m_dstm)
                val = m_valm;
            else if (src == m_dste)
                val = m_vale;
            else if (src == w_dstm)
                val = w_valm;
            else if (src == w_dste)
                val = w_vale;
        end
    end

endmodule

// File: rtl/decode_read.sv
// Decode/register-read stage: derives src/dst ids, reads and forwards operands into the E register.
// Latency: one cycle from accept to E.
// Backpressure: in_ready drops on a load-use hazard; a bubble is issued and D is held upstream.
module decode_read
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [63:0] R0,
    input  logic [63:0] R1,
    input  logic [63:0] R2,
    input  logic [63:0] R3,
    input  logic [63:0] R4,
    input  logic [63:0] R5,
    input  logic [63:0] R6,
    input  logic [63:0] R7,
    input  logic [63:0] R8,
    input  logic [63:0] R9,
    input  logic [63:0] R10,
    input  logic [63:0] R11,
    input  logic [63:0] R12,
    input  logic [63:0] R13,
    input  logic [63:0] R14,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstM,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] m_valM,
    input  logic [63:0] M_valE,
    input  logic [3:0]  W_dstM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valM,
    input  logic [63:0] W_valE,
    input  logic        flush,
    output logic        E_valid,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic        load_use
);

    logic [63:0] rf [16];
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] fwd_a, fwd_b, val_a;
    logic        accept;
    ereg_t       e_q, e_d;

    // Slot 15 is RNONE and reads as zero.
    assign rf[0]  = R0;
    assign rf[1]  = R1;
    assign rf[2]  = R2;
    assign rf[3]  = R3;
    assign rf[4]  = R4;
    assign rf[5]  = R5;
    assign rf[6]  = R6;
    assign rf[7]  = R7;
    assign rf[8]  = R8;
    assign rf[9]  = R9;
    assign rf[10] = R10;
    assign rf[11] = R11;
    assign rf[12] = R12;
    assign rf[13] = R13;
    assign rf[14] = R14;
    assign rf[15] = 64'h0;

    // cmov is treated as rrmovq here; the condition nullifies dstE in execute.
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            IRRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
            IIRMOVQ: begin dst_e = D_rB; end
            IRMMOVQ: begin src_a = D_rA; src_b = D_rB; end
            IMRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
            IOPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            ICALL:   begin src_b = RRSP; dst_e = RRSP; end
            IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
            IPUSHQ:  begin src_a = D_rA; src_b = RRSP; dst_e = RRSP; end
            IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = D_rA; end
            default: ;
        endcase
    end

    fwd_sel u_fwd_a (
        .src    (src_a),
        .rf_val (rf[src_a]),
        .e_dste (e_dstE),
        .e_vale (e_valE),
        .m_dstm (M_dstM),
        .m_valm (m_valM),
        .m_dste (M_dstE),
        .m_vale (M_valE),
        .w_dstm (W_dstM),
        .w_valm (W_valM),
        .w_dste (W_dstE),
        .w_vale (W_valE),
        .val    (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src    (src_b),
        .rf_val (rf[src_b]),
        .e_dste (e_dstE),
        .e_vale (e_valE),
        .m_dstm (M_dstM),
        .m_valm (m_valM),
        .m_dste (M_dstE),
        .m_vale (M_valE),
        .w_dstm (W_dstM),
        .w_valm (W_valM),
        .w_dste (W_dstE),
        .w_vale (W_valE),
        .val    (fwd_b)
    );

    assign val_a = (D_icode == IJXX || D_icode == ICALL) ? D_valP : fwd_a;

    // A load in E cannot forward its memory result in time; stall D one cycle.
    assign load_use = e_q.valid
                   && (e_q.icode == IMRMOVQ || e_q.icode == IPOPQ)
                   && (e_q.dstm != RNONE)
                   && (e_q.dstm == src_a || e_q.dstm == src_b);

    assign in_ready = ~load_use;
    assign accept   = in_valid & in_ready;

    always_comb begin
        e_d = E_BUBBLE;
        if (accept && !flush) begin
            e_d.valid = 1'b1;
            e_d.icode = D_icode;
            e_d.ifun  = D_ifun;
            e_d.srca  = src_a;
            e_d.srcb  = src_b;
            e_d.dste  = dst_e;
            e_d.dstm  = dst_m;
            e_d.valc  = D_valC;
            e_d.vala  = val_a;
            e_d.valb  = fwd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            e_q <= E_BUBBLE;
        else
            e_q <= e_d;
    end

    assign E_valid = e_q.valid;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;
    assign E_dstE  = e_q.dste;
    assign E_dstM  = e_q.dstm;
    assign E_valC  = e_q.valc;
    assign E_valA  = e_q.vala;
    assign E_valB  = e_q.valb;

endmodule

// File: tb/tb_decode_read.sv
// Directed bench for decode_read: decode, forward priority, load-use stall, flush and reset.
module tb_decode_read;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid, in_ready, flush, load_use;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [63:0] R [15];
    logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic        E_valid;
    logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_read dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .R0(R[0]), .R1(R[1]), .R2(R[2]), .R3(R[3]), .R4(R[4]),
        .R5(R[5]), .R6(R[6]), .R7(R[7]), .R8(R[8]), .R9(R[9]),
        .R10(R[10]), .R11(R[11]), .R12(R[12]), .R13(R[13]), .R14(R[14]),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstM(M_dstM), .M_dstE(M_dstE), .m_valM(m_valM), .M_valE(M_valE),
        .W_dstM(W_dstM), .W_dstE(W_dstE), .W_valM(W_valM), .W_valE(W_valE),
        .flush(flush),
        .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_srcA(E_srcA), .E_srcB(E_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .load_use(load_use)
    );

    task automatic clear_fwd();
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
        e_valE = 64'hE0; m_valM = 64'hE1; M_valE = 64'hE2; W_valM = 64'hE3; W_valE = 64'hE4;
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [3:0] ra, input logic [3:0] rb,
                             input logic [63:0] vc, input logic [63:0] vp);
        D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (E_valid !== 1'b0 || E_icode !== 4'h1 || E_ifun !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_ctl got valid=%b icode=%h ifun=%h exp 0/1/0", E_valid, E_icode, E_ifun);
        end
        vectors++;
        if (E_srcA !== 4'hF || E_srcB !== 4'hF || E_dstE !== 4'hF || E_dstM !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_ids got %h %h %h %h exp f f f f", E_srcA, E_srcB, E_dstE, E_dstM);
        end
        vectors++;
        if (E_valC !== 64'h0 || E_valA !== 64'h0 || E_valB !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_vals got %h %h %h exp 0", E_valC, E_valA, E_valB);
        end
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_opq();
        set_instr(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0);
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || load_use !== 1'b0) begin
            miscompares++;
            $display("FAIL opq_ready got rdy=%b lu=%b exp 1/0", in_ready, load_use);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (E_valid !== 1'b1 || E_icode !== 4'h6 || E_ifun !== 4'h1) begin
            miscompares++;
            $display("FAIL opq_ctl got %b %h %h exp 1 6 1", E_valid, E_icode, E_ifun);
        end
        vectors++;
        if (E_valA !== 64'd5 || E_valB !== 64'd7) begin
            miscompares++;
            $display("FAIL opq_vals got %h %h exp 5 7", E_valA, E_valB);
        end
        vectors++;
        if (E_srcA !== 4'h2 || E_srcB !== 4'h3 || E_dstE !== 4'h3 || E_dstM !== 4'hF) begin
            miscompares++;
            $display("FAIL opq_ids got %h %h %h %h exp 2 3 3 f", E_srcA, E_srcB, E_dstE, E_dstM);
        end
        tick();
        vectors++;
        if (E_valid !== 1'b0 || E_icode !== 4'h1) begin
            miscompares++;
            $display("FAIL idle_bubble got %b %h exp 0 1", E_valid, E_icode);
        end
    endtask

    // Peel forwards off one at a time; back-to-back accepts every cycle.
    task automatic test_back_to_back();
        logic [63:0] exp_a [6];
        exp_a[0] = 64'h11; exp_a[1] = 64'h44; exp_a[2] = 64'h22;
        exp_a[3] = 64'h33; exp_a[4] = 64'h55; exp_a[5] = 64'd5;
        set_instr(4'h2, 4'h0, 4'h2, 4'h5, 64'h0, 64'h0);
        e_dstE = 4'h2; e_valE = 64'h11;
        M_dstM = 4'h2; m_valM = 64'h44;
        M_dstE = 4'h2; M_valE = 64'h22;
        W_dstM = 4'h2; W_valM = 64'h33;
        W_dstE = 4'h2; W_valE = 64'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (E_valid !== 1'b1 || E_valA !== exp_a[i] || E_valB !== 64'h0 || E_dstE !== 4'h5) begin
                miscompares++;
                $display("FAIL fwd_step%0d got v=%b a=%h b=%h dstE=%h exp 1 %h 0 5",
                         i, E_valid, E_valA, E_valB, E_dstE, exp_a[i]);
            end
            case (i)
                0: e_dstE = 4'hF;
                1: M_dstM = 4'hF;
                2: M_dstE = 4'hF;
                3: W_dstM = 4'hF;
                4: W_dstE = 4'hF;
                default: ;
            endcase
        end
        in_valid = 1'b0;
        clear_fwd();
        tick();
    endtask

    task automatic test_illegal();
        set_instr(4'hC, 4'h3, 4'h2, 4'h3, 64'hDEAD, 64'h0);
        e_dstE = 4'hF; e_valE = 64'h99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clear_fwd();
        vectors++;
        if (E_valid !== 1'b1 || E_icode !== 4'hC || E_valC !== 64'hDEAD) begin
            miscompares++;
            $display("FAIL illegal_pass got %b %h %h exp 1 c dead", E_valid, E_icode, E_valC);
        end
        vectors++;
        if (E_srcA !== 4'hF || E_srcB !== 4'hF || E_dstE !== 4'hF || E_dstM !== 4'hF
            || E_valA !== 64'h0 || E_valB !== 64'h0) begin
            miscompares++;
            $display("FAIL illegal_rnone got %h %h %h %h a=%h b=%h exp f f f f 0 0",
                     E_srcA, E_srcB, E_dstE, E_dstM, E_valA, E_valB);
        end
    endtask

    task automatic test_load_use();
        set_instr(4'h5, 4'h0, 4'h6, 4'h3, 64'h8, 64'h0);
        in_valid = 1'b1;
        tick();
        vectors++;
        if (E_icode !== 4'h5 || E_dstM !== 4'h6 || E_srcB !== 4'h3 || E_dstE !== 4'hF) begin
            miscompares++;
            $display("FAIL mrmov_ids got %h %h %h %h exp 5 6 3 f", E_icode, E_dstM, E_srcB, E_dstE);
        end
        set_instr(4'h6, 4'h0, 4'h6, 4'h1, 64'h0, 64'h0);
        #1;
        vectors++;
        if (load_use !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_flag got lu=%b rdy=%b exp 1/0", load_use, in_ready);
        end
        tick();
        vectors++;
        if (E_valid !== 1'b0 || E_icode !== 4'h1 || E_dstE !== 4'hF) begin
            miscompares++;
            $display("FAIL lu_bubble got %b %h %h exp 0 1 f", E_valid, E_icode, E_dstE);
        end
        vectors++;
        if (load_use !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_release got lu=%b rdy=%b exp 0/1", load_use, in_ready);
        end
        M_dstM = 4'h6; m_valM = 64'h77;
        tick();
        in_valid = 1'b0;
        clear_fwd();
        vectors++;
        if (E_valid !== 1'b1 || E_valA !== 64'h77 || E_valB !== 64'h1001 || E_dstE !== 4'h1) begin
            miscompares++;
            $display("FAIL lu_accept got %b a=%h b=%h d=%h exp 1 77 1001 1", E_valid, E_valA, E_valB, E_dstE);
        end
    endtask

    task automatic test_call();
        set_instr(4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h40);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (E_valA !== 64'h40 || E_valB !== 64'h100 || E_dstE !== 4'h4 || E_srcB !== 4'h4 || E_srcA !== 4'hF) begin
            miscompares++;
            $display("FAIL call got a=%h b=%h dE=%h sB=%h sA=%h exp 40 100 4 4 f",
                     E_valA, E_valB, E_dstE, E_srcB, E_srcA);
        end
    endtask

    task automatic test_flush();
        set_instr(4'hB, 4'h0, 4'h6, 4'hF, 64'h0, 64'h0);
        in_valid = 1'b1;
        tick();
        vectors++;
        if (E_icode !== 4'hB || E_dstM !== 4'h6 || E_dstE !== 4'h4 || E_valA !== 64'h100) begin
            miscompares++;
            $display("FAIL popq got %h %h %h %h exp b 6 4 100", E_icode, E_dstM, E_dstE, E_valA);
        end
        set_instr(4'h6, 4'h0, 4'h6, 4'h1, 64'h0, 64'h0);
        flush = 1'b1;
        #1;
        vectors++;
        if (load_use !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_lu got %b exp 1", load_use);
        end
        tick();
        vectors++;
        if (E_valid !== 1'b0 || E_icode !== 4'h1 || E_valA !== 64'h0) begin
            miscompares++;
            $display("FAIL flush_bubble1 got %b %h %h exp 0 1 0", E_valid, E_icode, E_valA);
        end
        tick();
        flush = 1'b0;
        vectors++;
        if (E_valid !== 1'b0 || E_dstE !== 4'hF || E_srcA !== 4'hF) begin
            miscompares++;
            $display("FAIL flush_bubble2 got %b %h %h exp 0 f f", E_valid, E_dstE, E_srcA);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        set_instr(4'h3, 4'h0, 4'hF, 4'h9, 64'h1234, 64'h0);
        in_valid = 1'b1;
        tick();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (E_valid !== 1'b0 || E_icode !== 4'h1 || E_dstE !== 4'hF || E_valC !== 64'h0) begin
            miscompares++;
            $display("FAIL midreset got %b %h %h %h exp 0 1 f 0", E_valid, E_icode, E_dstE, E_valC);
        end
        #1 rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (E_valid !== 1'b1 || E_icode !== 4'h3 || E_dstE !== 4'h9 || E_valC !== 64'h1234) begin
            miscompares++;
            $display("FAIL post_reset got %b %h %h %h exp 1 3 9 1234", E_valid, E_icode, E_dstE, E_valC);
        end
    endtask

    initial begin
        for (int i = 0; i < 15; i++) R[i] = 64'h1000 + 64'(i);
        R[2] = 64'd5; R[3] = 64'd7; R[4] = 64'h100;
        in_valid = 1'b0;
        flush = 1'b0;
        clear_fwd();
        set_instr(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        test_reset();
        test_opq();
        test_back_to_back();
        test_illegal();
        test_load_use();
        test_call();
        test_flush();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
